// File: rtl/pixel_serializer.sv
// Pixel serializer: 24-bit words shifted out MSB first on a fixed framing.
// Define SER_REPEAT_LAST_EN to resend the last real word on underrun.
module pixel_serializer #(
    parameter int                 PIXEL_W   = 24,
    parameter logic [PIXEL_W-1:0] IDLE_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    output logic               serial_data,
    output logic               word_start,
    output logic               underrun
);

    localparam int               CNT_W    = $clog2(PIXEL_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIXEL_W - 1);

    logic [PIXEL_W-1:0] shift_reg;
    logic [PIXEL_W-1:0] hold_reg;
    logic [PIXEL_W-1:0] refill;
    logic [CNT_W-1:0]   bit_cnt;
    logic               hold_full;
    logic               fill;
    logic               load;
    logic               transfer;

    assign load        = (bit_cnt == CNT_LAST);
    assign pixel_ready = !hold_full || load;
    assign transfer    = pixel_valid && pixel_ready;

    assign serial_data = shift_reg[PIXEL_W-1];
    assign word_start  = (bit_cnt == '0);
    assign underrun    = fill;

`ifdef SER_REPEAT_LAST_EN
    logic [PIXEL_W-1:0] last_word;

    // Tracks the last real word so an underrun holds the static image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_word <= IDLE_WORD;
        end else if (load && hold_full) begin
            last_word <= hold_reg;
        end else if (load && transfer) begin
            last_word <= pixel_data;
        end
    end

    assign refill = last_word;
`else
    assign refill = IDLE_WORD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= IDLE_WORD;
            hold_reg  <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
            fill      <= 1'b1;
        end else if (load) begin
            bit_cnt <= '0;
            if (hold_full) begin
                // Drain the held pixel and refill the buffer on the same edge.
                shift_reg <= hold_reg;
                fill      <= 1'b0;
                hold_full <= transfer;
                if (transfer) begin
                    hold_reg <= pixel_data;
                end
            end else if (transfer) begin
                shift_reg <= pixel_data;
                fill      <= 1'b0;
            end else begin
                shift_reg <= refill;
                fill      <= 1'b1;
            end
        end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= {shift_reg[PIXEL_W-2:0], 1'b0};
            if (transfer) begin
                hold_reg  <= pixel_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_serializer.sv
// Scoreboard bench for pixel_serializer: accepted pixels are queued and
// compared word by word against the serial stream.
module tb_pixel_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        serial_data;
    logic        word_start;
    logic        underrun;

    pixel_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .serial_data (serial_data),
        .word_start  (word_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [23:0] got,
                       input logic [23:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    // Scoreboard model state
    logic [23:0] pend[$];
    logic [23:0] cur_word = '0;
    logic [23:0] last_sent = '0;
    logic        cur_fill = 1'b1;
    logic [23:0] rx = '0;
    logic        ws_bad = 1'b0;
    logic        uf_bad = 1'b0;
    int          cnt = 0;
    int          words = 0;

    function automatic logic [23:0] filler();
`ifdef SER_REPEAT_LAST_EN
        return last_sent;
`else
        return 24'h000000;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            cur_word  = '0;
            last_sent = '0;
            cur_fill  = 1'b1;
            cnt       = 0;
            ws_bad    = 1'b0;
            uf_bad    = 1'b0;
        end else begin
            rx = {rx[22:0], serial_data};
            if (word_start !== (cnt == 0)) ws_bad = 1'b1;
            if (underrun !== cur_fill) uf_bad = 1'b1;
            chk("ready", {23'd0, pixel_ready},
                {23'd0, (pend.size() == 0) || (cnt == 23)});
            if (cnt == 23) begin
                chk("word", rx, cur_word);
                chk("word_start", {23'd0, ws_bad}, 24'd0);
                chk("underrun", {23'd0, uf_bad}, 24'd0);
                words++;
                ws_bad = 1'b0;
                uf_bad = 1'b0;
            end
            if (pixel_valid && pixel_ready) pend.push_back(pixel_data);
            if (cnt == 23) begin
                if (pend.size() != 0) begin
                    cur_word  = pend.pop_front();
                    cur_fill  = 1'b0;
                    last_sent = cur_word;
                end else begin
                    cur_word = filler();
                    cur_fill = 1'b1;
                end
                cnt = 0;
            end else begin
                cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int c);
        int i;
        for (i = 0; i < 100 && cnt != c; i++) step(1);
        if (i == 100) chk("wait_cnt_timeout", cnt[23:0], c[23:0]);
    endtask

    // Holds valid until accepted; returns the cycle index of the transfer.
    task automatic send(input logic [23:0] d, output int t);
        int i;
        pixel_data  = d;
        pixel_valid = 1'b1;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pixel_ready) break;
        end
        if (i == 100) chk("send_timeout", d, 24'hxxxxxx);
        @(posedge clk);
        t = int'($time / 10);
        #1;
    endtask

    logic [23:0] stream[5] = '{24'h000001, 24'h800000, 24'hFFFFFF,
                               24'h5A5A5A, 24'hC3C3C3};
    int ts[5];
    int t0;

    initial begin
        // Reset values
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_serial", {23'd0, serial_data}, 24'd0);
        chk("rst_ws", {23'd0, word_start}, 24'd1);
        chk("rst_underrun", {23'd0, underrun}, 24'd1);
        chk("rst_ready", {23'd0, pixel_ready}, 24'd1);
        step(2);
        rst = 1'b0;

        // Idle: two filler words
        step(48);

        // Single pixel at the load edge goes out next cycle
        wait_cnt(23);
        chk("t2_ready", {23'd0, pixel_ready}, 24'd1);
        send(24'hA5C3F0, t0);
        pixel_valid = 1'b0;
        chk("t2_ws", {23'd0, word_start}, 24'd1);
        chk("t2_underrun", {23'd0, underrun}, 24'd0);
        chk("t2_msb", {23'd0, serial_data}, 24'd1);
        step(24);
        chk("t2_after", {23'd0, underrun}, 24'd1);

        // Continuous stream: one transfer per 24 clocks, no filler
        wait_cnt(3);
        for (int k = 0; k < 5; k++) send(stream[k], ts[k]);
        pixel_valid = 1'b0;
        for (int k = 2; k < 5; k++)
            chk("t3_interval", 24'(ts[k] - ts[k-1]), 24'd24);
        step(72);

        // Mid-word accept, second pixel stalls until load edge
        wait_cnt(10);
        chk("t4_ready_mid", {23'd0, pixel_ready}, 24'd1);
        send(24'h111111, t0);
        pixel_data = 24'h222222;
        chk("t4_stall", {23'd0, pixel_ready}, 24'd0);
        send(24'h222222, t0);
        pixel_valid = 1'b0;
        chk("t4_load_edge", {23'd0, word_start}, 24'd1);
        step(60);

        // Reset mid-word with hold full
        wait_cnt(5);
        send(24'h333333, t0);
        pixel_valid = 1'b0;
        wait_cnt(12);
        chk("t5_hold_full", {23'd0, pixel_ready}, 24'd0);
        rst = 1'b1;
        #1;
        chk("t5_rst_serial", {23'd0, serial_data}, 24'd0);
        chk("t5_rst_ws", {23'd0, word_start}, 24'd1);
        chk("t5_rst_underrun", {23'd0, underrun}, 24'd1);
        chk("t5_rst_ready", {23'd0, pixel_ready}, 24'd1);
        step(2);
        rst = 1'b0;
        step(48);

        // Send one word then stop: filler follows
        wait_cnt(23);
        send(24'h123456, t0);
        pixel_valid = 1'b0;
        step(24);
        chk("t6_underrun", {23'd0, underrun}, 24'd1);
        step(50);

        chk("words_seen", {23'd0, words > 20}, 24'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
